// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction-fetch / data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_e;

  localparam logic [3:0] WMASK_WORD = 4'hF;
  localparam logic [3:0] WMASK_NONE = 4'h0;

  // Everything the arbiter remembers between grant and response, kept in one
  // packed struct so checkers can bind to a single observable register.
  typedef struct packed {
    state_e     state;
    owner_e     owner;
    logic [3:0] starve_cnt;
    logic       byte_op;
    logic [1:0] lane;
    logic       we;
  } arb_state_t;

  localparam arb_state_t ARB_RESET = '{
    state:      IDLE,
    owner:      NONE,
    starve_cnt: 4'd0,
    byte_op:    1'b0,
    lane:       2'b00,
    we:         1'b0
  };

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane formatting: positions store data / builds the write mask, and
// extracts and zero-extends the addressed byte of a load response.
module byte_lane_unit
  import mem_arb_pkg::*;
(
  input  logic        st_byte,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_wdata_pos,
  input  logic        ld_byte,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  always_comb begin
    st_wmask     = WMASK_WORD;
    st_wdata_pos = st_wdata;
    if (st_byte) begin
      st_wmask     = 4'b0001 << st_lane;
      st_wdata_pos = {24'd0, st_wdata[7:0]} << {st_lane, 3'b000};
    end
  end

  always_comb begin
    ld_data = ld_rdata;
    if (ld_byte) begin
      case (ld_lane)
        2'd0:    ld_data = {24'd0, ld_rdata[7:0]};
        2'd1:    ld_data = {24'd0, ld_rdata[15:8]};
        2'd2:    ld_data = {24'd0, ld_rdata[23:16]};
        default: ld_data = {24'd0, ld_rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters: data has priority,
// a starvation counter forces a fetch win, one transaction outstanding at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a requester holds req with its fields stable until the cycle
  // its gnt is high; gnt and mem_req are combinational in IDLE, rvalid is a
  // one-cycle pulse combinational from mem_rvalid while BUSY.
  arb_state_t arb_q, arb_d;

  logic        fetch_wins, data_wins;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata_pos, ld_data;

  byte_lane_unit u_lane (
    .st_byte      (d_byte),
    .st_lane      (d_addr[1:0]),
    .st_wdata     (d_wdata),
    .st_wmask     (st_wmask),
    .st_wdata_pos (st_wdata_pos),
    .ld_byte      (arb_q.byte_op),
    .ld_lane      (arb_q.lane),
    .ld_rdata     (mem_rdata),
    .ld_data      (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_q <= ARB_RESET;
    else        arb_q <= arb_d;
  end

  // Gating with rst_n keeps every strobe low while reset is held.
  assign fetch_wins = rst_n && (arb_q.state == IDLE) && if_req &&
                      (!d_req || (arb_q.starve_cnt == LIMIT));
  assign data_wins  = rst_n && (arb_q.state == IDLE) && d_req && !fetch_wins;

  always_comb begin
    arb_d     = arb_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    mem_wmask = WMASK_NONE;

    case (arb_q.state)
      IDLE: begin
        if (fetch_wins) begin
          if_gnt           = 1'b1;
          mem_req          = 1'b1;
          mem_addr         = {if_addr[ADDR_W-1:2], 2'b00};
          arb_d.state      = BUSY;
          arb_d.owner      = FETCH;
          arb_d.starve_cnt = 4'd0;
          arb_d.byte_op    = 1'b0;
          arb_d.lane       = if_addr[1:0];
          arb_d.we         = 1'b0;
        end else if (data_wins) begin
          d_gnt          = 1'b1;
          mem_req        = 1'b1;
          mem_we         = d_we;
          mem_addr       = {d_addr[ADDR_W-1:2], 2'b00};
          mem_wmask      = d_we ? st_wmask : WMASK_NONE;
          mem_wdata      = d_we ? st_wdata_pos : 32'd0;
          arb_d.state    = BUSY;
          arb_d.owner    = DATA;
          arb_d.byte_op  = d_byte;
          arb_d.lane     = d_addr[1:0];
          arb_d.we       = d_we;
          if (if_req && (arb_q.starve_cnt < LIMIT))
            arb_d.starve_cnt = arb_q.starve_cnt + 4'd1;
        end
      end
      BUSY: begin
        if (mem_rvalid) begin
          if (arb_q.owner == FETCH) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else if (arb_q.owner == DATA) begin
            d_rvalid = 1'b1;
            d_rdata  = arb_q.we ? 32'd0 : ld_data;
          end
          arb_d.state = IDLE;
          arb_d.owner = NONE;
        end
      end
      default: arb_d = ARB_RESET;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_byte = 1'b0;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({if_gnt, d_gnt, mem_req, mem_we} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {if_gnt, d_gnt, mem_req, mem_we}); end
    checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {if_rvalid, d_rvalid}); end
    checks++; if (mem_addr !== 32'd0 || mem_wmask !== 4'h0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem got addr %h mask %h wdata %h exp 0", mem_addr, mem_wmask, mem_wdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_idle_rvalid();
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
    checks++; if ({if_rvalid, d_rvalid, mem_req} !== 3'b000) begin errors++; $display("FAIL idle_rvalid got %b exp 000", {if_rvalid, d_rvalid, mem_req}); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_fetch_only();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h100; #1;
    checks++; if ({if_gnt, d_gnt, mem_req} !== 3'b101) begin errors++; $display("FAIL fetch_gnt got %b exp 101", {if_gnt, d_gnt, mem_req}); end
    checks++; if (mem_addr !== 32'h100 || mem_wmask !== 4'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem got addr %h mask %h we %b exp 100 0 0", mem_addr, mem_wmask, mem_we); end
    @(negedge clk); if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093; #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_resp got %b %h exp 1 00500093", if_rvalid, if_rdata); end
    checks++; if ({d_rvalid, if_gnt, mem_req} !== 3'b000) begin errors++; $display("FAIL fetch_resp_side got %b exp 000", {d_rvalid, if_gnt, mem_req}); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b exp 0", if_rvalid); end
  endtask

  task automatic test_starvation();
    bit exp_f [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if_req = 1'b1; if_addr = 32'h180;
      d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h300;
      #1;
      checks++; if (if_gnt !== exp_f[i] || d_gnt !== !exp_f[i]) begin errors++; $display("FAIL starve_gnt[%0d] got if %b d %b exp if %b", i, if_gnt, d_gnt, exp_f[i]); end
      @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h1000 + i; #1;
      checks++; if (if_rvalid !== exp_f[i] || d_rvalid !== !exp_f[i]) begin errors++; $display("FAIL starve_rv[%0d] got if %b d %b exp if %b", i, if_rvalid, d_rvalid, exp_f[i]); end
      if (!exp_f[i]) begin
        checks++; if (d_rdata !== 32'h1000 + i) begin errors++; $display("FAIL starve_rdata[%0d] got %h exp %h", i, d_rdata, 32'h1000 + i); end
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_sb();
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 32'h203; d_wdata = 32'h1234_56AB; #1;
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sb_gnt got gnt %b we %b exp 1 1", d_gnt, mem_we); end
    checks++; if (mem_addr !== 32'h200 || mem_wmask !== 4'h8 || mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb_mem got %h %h %h exp 200 8 ab000000", mem_addr, mem_wmask, mem_wdata); end
    @(negedge clk); d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'd0) begin errors++; $display("FAIL sb_resp got %b %h exp 1 00000000", d_rvalid, d_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_sw_misaligned();
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 32'h405; d_wdata = 32'hCAFE_F00D; #1;
    checks++; if (mem_addr !== 32'h404 || mem_wmask !== 4'hF || mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_mem got %h %h %h exp 404 f cafef00d", mem_addr, mem_wmask, mem_wdata); end
    @(negedge clk); d_req = 1'b0; mem_rvalid = 1'b1; #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'd0) begin errors++; $display("FAIL sw_resp got %b %h exp 1 0", d_rvalid, d_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_lbu();
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_byte = 1'b1; d_addr = 32'h202; #1;
    checks++; if (mem_addr !== 32'h200 || mem_wmask !== 4'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL lbu_mem got %h %h %b exp 200 0 0", mem_addr, mem_wmask, mem_we); end
    // Address bits change after the grant; the response must use the latched lane.
    @(negedge clk); d_req = 1'b0; d_addr = 32'h201; d_byte = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344; #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000_0022) begin errors++; $display("FAIL lbu_resp got %b %h exp 1 00000022", d_rvalid, d_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_busy();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rstb_gnt got %b exp 1", if_gnt); end
    @(negedge clk); if_req = 1'b0; rst_n = 1'b0; #1;
    checks++; if ({if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid} !== 5'b0) begin errors++; $display("FAIL rstb_out got %b exp 00000", {if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid}); end
    @(negedge clk); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999; #1;
    checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL rstb_stale got %b exp 00", {if_rvalid, d_rvalid}); end
    @(negedge clk); mem_rvalid = 1'b0; d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h500; #1;
    checks++; if (d_gnt !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL rstb_next got %b %h exp 1 500", d_gnt, mem_addr); end
    @(negedge clk); d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h55) begin errors++; $display("FAIL rstb_resp got %b %h exp 1 55", d_rvalid, d_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h600; #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL lat_gnt got %b exp 1", d_gnt); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++; if ({d_gnt, mem_req, d_rvalid} !== 3'b000) begin errors++; $display("FAIL lat_wait[%0d] got %b exp 000", k, {d_gnt, mem_req, d_rvalid}); end
    end
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h77; #1;
    checks++; if (d_rvalid !== 1'b1 || d_gnt !== 1'b0 || d_rdata !== 32'h77) begin errors++; $display("FAIL lat_resp got rv %b gnt %b %h exp 1 0 77", d_rvalid, d_gnt, d_rdata); end
    @(negedge clk); mem_rvalid = 1'b0; #1;
    checks++; if (d_gnt !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL lat_regnt got gnt %b rv %b exp 1 0", d_gnt, d_rvalid); end
    // Fetch raises and drops its request entirely inside BUSY: it must never be granted.
    @(negedge clk); d_req = 1'b0; if_req = 1'b1; #1;
    @(negedge clk); if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h88; #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h88) begin errors++; $display("FAIL lat_resp2 got %b %h exp 1 88", d_rvalid, d_rdata); end
    @(negedge clk); mem_rvalid = 1'b0; #1;
    checks++; if ({if_gnt, d_gnt, mem_req, d_rvalid} !== 4'b0000) begin errors++; $display("FAIL lat_drop got %b exp 0000", {if_gnt, d_gnt, mem_req, d_rvalid}); end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_idle_rvalid();
    test_fetch_only();
    test_starvation();
    test_sb();
    test_sw_misaligned();
    test_lbu();
    test_reset_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
